// File: rtl/can_reg_pkg.sv
// Shared definitions for the SJA1000-style (BasicCAN) command sequencer:
// register map, status bit positions, access select codes, the FSM state
// encoding and the access request record passed to the access issuer.
package can_reg_pkg;

  localparam logic [7:0] CR_ADDR   = 8'd0;
  localparam logic [7:0] CMR_ADDR  = 8'd1;
  localparam logic [7:0] SR_ADDR   = 8'd2;
  localparam logic [7:0] ACR_ADDR  = 8'd4;
  localparam logic [7:0] AMR_ADDR  = 8'd5;
  localparam logic [7:0] BTR0_ADDR = 8'd6;
  localparam logic [7:0] BTR1_ADDR = 8'd7;
  localparam logic [7:0] OCR_ADDR  = 8'd8;
  localparam logic [7:0] TXB_ADDR  = 8'd10;

  localparam int SR_TBS_BIT = 2;

  localparam logic [1:0] NO_SEL = 2'b00;
  localparam logic [1:0] WR_SEL = 2'b01;
  localparam logic [1:0] RD_SEL = 2'b10;

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_POLL, ST_TXBUF, ST_CMD, ST_DONE
  } state_t;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_req_t;

  // Data bytes actually sent: none for remote frames, DLC 9..15 clamps to 8.
  function automatic logic [3:0] nbytes_of(input logic rtr, input logic [3:0] dlc);
    if (rtr) return 4'd0;
    return (dlc > 4'd8) ? 4'd8 : dlc;
  endfunction

endpackage

// File: rtl/can_acc_issuer.sv
// Single-access issuer towards the CAN bus master.
// start/sel/addr/wdata : access request, taken when free
// req, req_sel/addr/data: one-cycle request pulse; sel/addr/data held for
//                         the ACC_GAP-cycle window, then cleared
// rd_addr/rd_data/rd_valid: read-back from the bus master
// free    : a new request may be taken this cycle
// done    : last cycle of the current access window
// rdata   : read data (valid with done on a matched read)
// timeout : read window ended without a matching read-back
module can_acc_issuer
  import can_reg_pkg::*;
#(
  parameter int ACC_GAP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] sel,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  input  logic       rd_valid,
  output logic       req,
  output logic [1:0] req_sel,
  output logic [7:0] req_addr,
  output logic [7:0] req_data,
  output logic       free,
  output logic       done,
  output logic [7:0] rdata,
  output logic       timeout
);

  localparam int CW = (ACC_GAP > 2) ? $clog2(ACC_GAP) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACC_GAP - 1);

  logic          active;
  logic          is_rd;
  logic          matched;
  logic [CW-1:0] cnt;
  logic [7:0]    rbuf;
  logic          hit;

  assign done    = active && (cnt == LAST);
  // Back-to-back accesses: a new request may start in the closing cycle.
  assign free    = !active || done;
  assign hit     = active && is_rd && rd_valid && (rd_addr == req_addr);
  // A match landing in the closing cycle is forwarded straight through.
  assign rdata   = matched ? rbuf : rd_data;
  assign timeout = done && is_rd && !(matched || hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      is_rd    <= 1'b0;
      matched  <= 1'b0;
      cnt      <= '0;
      rbuf     <= '0;
      req      <= 1'b0;
      req_sel  <= NO_SEL;
      req_addr <= '0;
      req_data <= '0;
    end else begin
      req <= 1'b0;
      if (hit && !matched) begin
        matched <= 1'b1;
        rbuf    <= rd_data;
      end
      if (start && free) begin
        active   <= 1'b1;
        cnt      <= '0;
        req      <= 1'b1;
        req_sel  <= sel;
        req_addr <= addr;
        req_data <= wdata;
        is_rd    <= (sel == RD_SEL);
        matched  <= 1'b0;
      end else if (done) begin
        active   <= 1'b0;
        is_rd    <= 1'b0;
        req_sel  <= NO_SEL;
        req_addr <= '0;
        req_data <= '0;
      end else if (active) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/can_tx_frame_ctrl.sv
// CAN TX frame command sequencer (BasicCAN mode).
// Programs the controller after reset, then for every frame accepted on the
// valid/ready port polls SR until TBS, writes the TX buffer and issues the
// transmit command through can_acc_issuer.
// Ports: sys_clk/sys_reset (sync, active high); i_tx_* frame in, o_tx_ready;
// o_can_* access request out, i_can_rd_* read-back in; o_init_done level;
// o_tx_done / o_err_timeout one-cycle pulses.
module can_tx_frame_ctrl
  import can_reg_pkg::*;
#(
  parameter int         ACC_GAP  = 8,
  parameter int         POLL_MAX = 255,
  parameter logic [7:0] ACR_VAL  = 8'h00,
  parameter logic [7:0] AMR_VAL  = 8'hFF,
  parameter logic [7:0] BTR0_VAL = 8'h00,
  parameter logic [7:0] BTR1_VAL = 8'h14,
  parameter logic [7:0] OCR_VAL  = 8'hDA
) (
  input  logic        sys_clk,
  input  logic        sys_reset,
  input  logic        i_tx_valid,
  output logic        o_tx_ready,
  input  logic [10:0] i_tx_id,
  input  logic        i_tx_rtr,
  input  logic [3:0]  i_tx_dlc,
  input  logic [63:0] i_tx_data,
  output logic [1:0]  o_can_wr_sel,
  output logic [7:0]  o_can_wr_addr,
  output logic [7:0]  o_can_data,
  output logic        o_can_data_valid,
  input  logic [7:0]  i_can_rd_addr,
  input  logic [7:0]  i_can_rd_data,
  input  logic        i_can_rd_valid,
  output logic        o_init_done,
  output logic        o_tx_done,
  output logic        o_err_timeout
);

  localparam logic [7:0] POLL_LAST = 8'(POLL_MAX - 1);

  state_t      state, state_n;
  logic [3:0]  idx, idx_n;
  logic [7:0]  poll_cnt, poll_n;
  logic        init_done_n, tx_done_n, err_n, cap;
  logic [10:0] f_id;
  logic        f_rtr;
  logic [3:0]  f_dlc, f_nbytes;
  logic [63:0] f_data;
  logic [3:0]  boff;
  acc_req_t    acc;
  logic        start, acc_free, acc_done, acc_timeout;
  logic [7:0]  acc_rdata;

  assign o_tx_ready = (state == ST_IDLE) && o_init_done;

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state         <= ST_INIT;
      idx           <= '0;
      poll_cnt      <= '0;
      o_init_done   <= 1'b0;
      o_tx_done     <= 1'b0;
      o_err_timeout <= 1'b0;
      f_id          <= '0;
      f_rtr         <= 1'b0;
      f_dlc         <= '0;
      f_nbytes      <= '0;
      f_data        <= '0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      poll_cnt      <= poll_n;
      o_init_done   <= init_done_n;
      o_tx_done     <= tx_done_n;
      o_err_timeout <= err_n;
      if (cap) begin
        f_id     <= i_tx_id;
        f_rtr    <= i_tx_rtr;
        f_dlc    <= i_tx_dlc;
        f_nbytes <= nbytes_of(i_tx_rtr, i_tx_dlc);
        f_data   <= i_tx_data;
      end
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    poll_n      = poll_cnt;
    init_done_n = o_init_done;
    tx_done_n   = 1'b0;
    err_n       = 1'b0;
    cap         = 1'b0;
    case (state)
      ST_INIT: if (acc_done) begin
        if (idx == 4'd6) begin
          state_n     = ST_IDLE;
          idx_n       = '0;
          init_done_n = 1'b1;
        end else begin
          idx_n = idx + 4'd1;
        end
      end
      ST_IDLE: if (i_tx_valid && o_tx_ready) begin
        cap     = 1'b1;
        state_n = ST_POLL;
        poll_n  = '0;
        idx_n   = '0;
      end
      ST_POLL: if (acc_done) begin
        if (acc_timeout) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end else if (acc_rdata[SR_TBS_BIT]) begin
          state_n = ST_TXBUF;
          idx_n   = '0;
        end else if (poll_cnt == POLL_LAST) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end else begin
          poll_n = poll_cnt + 8'd1;
        end
      end
      // idx 0/1 are the two ID bytes, idx 2+k is data byte k.
      ST_TXBUF: if (acc_done) begin
        if (idx == 4'd1 + f_nbytes) state_n = ST_CMD;
        else                        idx_n   = idx + 4'd1;
      end
      ST_CMD: if (acc_done) begin
        state_n   = ST_DONE;
        tx_done_n = 1'b1;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_INIT;
    endcase

    // The request is built from the next state so a following access can
    // launch in the closing cycle of the current window.
    boff = idx_n - 4'd2;
    acc  = '{sel: WR_SEL, addr: CR_ADDR, data: 8'h00};
    case (state_n)
      ST_INIT: case (idx_n)
        4'd0:    acc = '{sel: WR_SEL, addr: CR_ADDR,   data: 8'h01};
        4'd1:    acc = '{sel: WR_SEL, addr: ACR_ADDR,  data: ACR_VAL};
        4'd2:    acc = '{sel: WR_SEL, addr: AMR_ADDR,  data: AMR_VAL};
        4'd3:    acc = '{sel: WR_SEL, addr: BTR0_ADDR, data: BTR0_VAL};
        4'd4:    acc = '{sel: WR_SEL, addr: BTR1_ADDR, data: BTR1_VAL};
        4'd5:    acc = '{sel: WR_SEL, addr: OCR_ADDR,  data: OCR_VAL};
        default: acc = '{sel: WR_SEL, addr: CR_ADDR,   data: 8'h00};
      endcase
      ST_POLL:  acc = '{sel: RD_SEL, addr: SR_ADDR, data: 8'h00};
      ST_TXBUF: begin
        acc.sel  = WR_SEL;
        acc.addr = TXB_ADDR + {4'b0000, idx_n};
        if (idx_n == 4'd0)      acc.data = f_id[10:3];
        else if (idx_n == 4'd1) acc.data = {f_id[2:0], f_rtr, f_dlc};
        else                    acc.data = f_data[{boff[2:0], 3'b000} +: 8];
      end
      ST_CMD:   acc = '{sel: WR_SEL, addr: CMR_ADDR, data: 8'h01};
      default:  acc = '{sel: WR_SEL, addr: CR_ADDR, data: 8'h00};
    endcase
    start = acc_free && (state_n inside {ST_INIT, ST_POLL, ST_TXBUF, ST_CMD});
  end

  can_acc_issuer #(.ACC_GAP(ACC_GAP)) u_issuer (
    .clk      (sys_clk),
    .rst      (sys_reset),
    .start    (start),
    .sel      (acc.sel),
    .addr     (acc.addr),
    .wdata    (acc.data),
    .rd_addr  (i_can_rd_addr),
    .rd_data  (i_can_rd_data),
    .rd_valid (i_can_rd_valid),
    .req      (o_can_data_valid),
    .req_sel  (o_can_wr_sel),
    .req_addr (o_can_wr_addr),
    .req_data (o_can_data),
    .free     (acc_free),
    .done     (acc_done),
    .rdata    (acc_rdata),
    .timeout  (acc_timeout)
  );

endmodule

// File: tb/tb_can_tx_frame_ctrl.sv
// Self-checking bench for can_tx_frame_ctrl: a bus-master/register model
// answers SR reads (with a wrong-address decoy before each real answer), and
// an expected-access queue built from frame contents is checked on every
// request pulse, together with hold, spacing, pulse and throughput checks.
module tb_can_tx_frame_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_reset = 1'b1;
  logic        i_tx_valid;
  logic        o_tx_ready;
  logic [10:0] i_tx_id;
  logic        i_tx_rtr;
  logic [3:0]  i_tx_dlc;
  logic [63:0] i_tx_data;
  logic [1:0]  o_can_wr_sel;
  logic [7:0]  o_can_wr_addr;
  logic [7:0]  o_can_data;
  logic        o_can_data_valid;
  logic [7:0]  i_can_rd_addr;
  logic [7:0]  i_can_rd_data;
  logic        i_can_rd_valid;
  logic        o_init_done;
  logic        o_tx_done;
  logic        o_err_timeout;

  can_tx_frame_ctrl dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset),
    .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
    .i_tx_id(i_tx_id), .i_tx_rtr(i_tx_rtr), .i_tx_dlc(i_tx_dlc), .i_tx_data(i_tx_data),
    .o_can_wr_sel(o_can_wr_sel), .o_can_wr_addr(o_can_wr_addr), .o_can_data(o_can_data),
    .o_can_data_valid(o_can_data_valid),
    .i_can_rd_addr(i_can_rd_addr), .i_can_rd_data(i_can_rd_data), .i_can_rd_valid(i_can_rd_valid),
    .o_init_done(o_init_done), .o_tx_done(o_tx_done), .o_err_timeout(o_err_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_t;

  acc_t exp_q[$];
  int   pulse_cyc[$];
  int   tests = 0, fails = 0;
  int   cyc = 0;
  int   n_done = 0, n_err = 0;
  int   sr_zero = 0, sr_reads = 0;
  bit   resp_drop = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic acc_t mk(input logic [1:0] s, input logic [7:0] a, input logic [7:0] d);
    return {s, a, d};
  endfunction

  // ---------------- model: expected access lists ----------------
  task automatic push_init();
    exp_q.push_back(mk(2'b01, 8'd0, 8'h01));
    exp_q.push_back(mk(2'b01, 8'd4, 8'h00));
    exp_q.push_back(mk(2'b01, 8'd5, 8'hFF));
    exp_q.push_back(mk(2'b01, 8'd6, 8'h00));
    exp_q.push_back(mk(2'b01, 8'd7, 8'h14));
    exp_q.push_back(mk(2'b01, 8'd8, 8'hDA));
    exp_q.push_back(mk(2'b01, 8'd0, 8'h00));
  endtask

  task automatic push_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                            input logic [63:0] d, input int reads, input bit sent);
    int n;
    for (int i = 0; i < reads; i++) exp_q.push_back(mk(2'b10, 8'd2, 8'h00));
    if (sent) begin
      n = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
      exp_q.push_back(mk(2'b01, 8'd10, id[10:3]));
      exp_q.push_back(mk(2'b01, 8'd11, {id[2:0], rtr, dlc}));
      for (int k = 0; k < n; k++) exp_q.push_back(mk(2'b01, 8'(12 + k), d[8*k +: 8]));
      exp_q.push_back(mk(2'b01, 8'd1, 8'h01));
    end
  endtask

  // ---------------- compare process ----------------
  acc_t mon_a, mon_e, held;
  int   hold_left = 0, last_p = -1;

  always @(negedge sys_clk) begin
    if (sys_reset) begin
      hold_left = 0;
      last_p = -1;
    end else begin
      if (o_tx_done) n_done++;
      if (o_err_timeout) n_err++;
      mon_a = {o_can_wr_sel, o_can_wr_addr, o_can_data};
      if (o_can_data_valid) begin
        chk("pulse_spacing_ge_gap", (last_p < 0) || (cyc - last_p >= 8), 1'b1);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_access: got sel=%b addr=%0d data=%h, want no access", mon_a.sel, mon_a.addr, mon_a.data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("acc_sel", mon_a.sel, mon_e.sel);
          chk("acc_addr", mon_a.addr, mon_e.addr);
          if (mon_e.sel == 2'b01) chk("acc_wdata", mon_a.data, mon_e.data);
        end
        pulse_cyc.push_back(cyc);
        last_p = cyc;
        held = mon_a;
        hold_left = 7;
      end else if (hold_left > 0) begin
        chk("acc_hold", mon_a, held);
        hold_left--;
      end
    end
  end

  // ---------------- bus master / register model ----------------
  int         resp_cnt = 0;
  logic [7:0] resp_addr = 8'h00;

  initial begin
    i_can_rd_valid = 1'b0;
    i_can_rd_addr  = 8'h00;
    i_can_rd_data  = 8'h00;
    forever begin
      @(negedge sys_clk);
      i_can_rd_valid = 1'b0;
      if (sys_reset) resp_cnt = 0;
      else begin
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 1) begin
            // decoy strobe for another address; must not be taken as SR
            i_can_rd_valid = 1'b1;
            i_can_rd_addr  = resp_addr + 8'd1;
            i_can_rd_data  = 8'hFF;
          end else if (resp_cnt == 0 && !resp_drop) begin
            i_can_rd_valid = 1'b1;
            i_can_rd_addr  = resp_addr;
            i_can_rd_data  = (sr_reads < sr_zero) ? 8'h08 : 8'h0C;
            sr_reads++;
          end
        end
        if (o_can_data_valid && o_can_wr_sel == 2'b10) begin
          resp_cnt  = 3;
          resp_addr = o_can_wr_addr;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic offer(input logic [10:0] id, input logic rtr, input logic [3:0] dlc, input logic [63:0] d);
    i_tx_id = id; i_tx_rtr = rtr; i_tx_dlc = dlc; i_tx_data = d;
    i_tx_valid = 1'b1;
  endtask

  int t_acc;

  task automatic accept();
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (o_tx_ready && i_tx_valid) seen = 1'b1;
      else tick();
    end
    chk("frame_accepted", seen, 1'b1);
    t_acc = cyc;
    pulse_cyc.delete();
    sr_reads = 0;
    tick();
    i_tx_valid = 1'b0;
    chk("ready_dropped", o_tx_ready, 1'b0);
  endtask

  task automatic finish_frame(input int n_acc, input bit ok);
    int t_rdy;
    for (int i = 0; i < 5000 && !o_tx_done && !o_err_timeout; i++) tick();
    chk("tx_done_pulse", o_tx_done, ok);
    chk("err_timeout_pulse", o_err_timeout, !ok);
    if (ok) begin
      chk("access_count", pulse_cyc.size(), n_acc);
      for (int i = 1; i < pulse_cyc.size(); i++)
        chk("frame_gap", pulse_cyc[i] - pulse_cyc[i-1], 8);
    end
    tick();
    chk("pulse_one_cycle", o_tx_done | o_err_timeout, 1'b0);
    for (int i = 0; i < 10 && !o_tx_ready; i++) tick();
    t_rdy = cyc;
    chk("ready_again", o_tx_ready, 1'b1);
    if (ok) chk("frame_period", t_rdy - t_acc, 8 * n_acc + 2);
    chk("expected_drained", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  int done_before;

  initial begin
    i_tx_valid = 1'b0; i_tx_id = '0; i_tx_rtr = 1'b0; i_tx_dlc = '0; i_tx_data = '0;
    sys_reset = 1'b1;
    repeat (3) tick();
    chk("rst_valid", o_can_data_valid, 1'b0);
    chk("rst_sel", o_can_wr_sel, 2'b00);
    chk("rst_addr", o_can_wr_addr, 8'h00);
    chk("rst_data", o_can_data, 8'h00);
    chk("rst_ready", o_tx_ready, 1'b0);
    chk("rst_init_done", o_init_done, 1'b0);
    chk("rst_tx_done", o_tx_done, 1'b0);
    chk("rst_err", o_err_timeout, 1'b0);

    // 1 + 2: init sequence; frame offered during init must wait for it
    push_init();
    push_frame(11'h123, 1'b0, 4'd2, 64'hBBAA, 1, 1'b1);
    chk("model_f2_len", exp_q.size(), 13);
    chk("model_f2_idhi", exp_q[8], mk(2'b01, 8'd10, 8'h24));
    chk("model_f2_idlo", exp_q[9], mk(2'b01, 8'd11, 8'h62));
    chk("model_f2_b0", exp_q[10], mk(2'b01, 8'd12, 8'hAA));
    chk("model_f2_b1", exp_q[11], mk(2'b01, 8'd13, 8'hBB));
    sr_zero = 0;
    offer(11'h123, 1'b0, 4'd2, 64'hBBAA);
    sys_reset = 1'b0;
    repeat (20) tick();
    chk("ready_during_init", o_tx_ready, 1'b0);
    chk("init_done_early", o_init_done, 1'b0);
    for (int i = 0; i < 200 && !o_init_done; i++) tick();
    chk("init_done", o_init_done, 1'b1);
    chk("init_write_count", pulse_cyc.size(), 7);
    if (pulse_cyc.size() == 7) begin
      for (int i = 1; i < 7; i++) chk("init_gap", pulse_cyc[i] - pulse_cyc[i-1], 8);
      chk("init_done_after_window", cyc - pulse_cyc[6], 8);
    end
    accept();
    finish_frame(6, 1'b1);

    // 3: remote frame, no data bytes
    push_frame(11'h7FF, 1'b1, 4'd4, 64'h1122334455667788, 1, 1'b1);
    chk("model_f3_len", exp_q.size(), 4);
    chk("model_f3_idlo", exp_q[2], mk(2'b01, 8'd11, 8'hF4));
    sr_zero = 0;
    offer(11'h7FF, 1'b1, 4'd4, 64'h1122334455667788);
    accept();
    finish_frame(4, 1'b1);

    // 4: three busy polls, DLC 12 clamps to 8 data bytes
    push_frame(11'h0A5, 1'b0, 4'd12, 64'h0807060504030201, 4, 1'b1);
    chk("model_f4_len", exp_q.size(), 15);
    chk("model_f4_dlc", exp_q[5].data[3:0], 4'hC);
    chk("model_f4_last_byte", exp_q[13], mk(2'b01, 8'd19, 8'h08));
    sr_zero = 3;
    offer(11'h0A5, 1'b0, 4'd12, 64'h0807060504030201);
    accept();
    finish_frame(15, 1'b1);
    chk("f4_sr_reads", sr_reads, 4);

    // 5: TBS stuck at 0 -> 255 reads then drop
    push_frame(11'h321, 1'b0, 4'd1, 64'h5A, 255, 1'b0);
    sr_zero = 100000;
    offer(11'h321, 1'b0, 4'd1, 64'h5A);
    accept();
    finish_frame(255, 1'b0);
    chk("f5_sr_reads", sr_reads, 255);

    // read-back never matches -> timeout after one read window
    push_frame(11'h010, 1'b0, 4'd3, 64'h333333, 1, 1'b0);
    sr_zero = 0;
    resp_drop = 1'b1;
    offer(11'h010, 1'b0, 4'd3, 64'h333333);
    accept();
    finish_frame(1, 1'b0);
    resp_drop = 1'b0;

    // 6: reset in the middle of the TX buffer writes
    push_frame(11'h555, 1'b0, 4'd8, 64'h8877665544332211, 1, 1'b1);
    sr_zero = 0;
    offer(11'h555, 1'b0, 4'd8, 64'h8877665544332211);
    accept();
    for (int i = 0; i < 200 && pulse_cyc.size() < 5; i++) tick();
    chk("reached_txbuf", pulse_cyc.size() >= 5, 1'b1);
    done_before = n_done;
    sys_reset = 1'b1;
    tick();
    chk("midrst_valid", o_can_data_valid, 1'b0);
    chk("midrst_sel", o_can_wr_sel, 2'b00);
    chk("midrst_addr", o_can_wr_addr, 8'h00);
    chk("midrst_data", o_can_data, 8'h00);
    chk("midrst_ready", o_tx_ready, 1'b0);
    chk("midrst_init_done", o_init_done, 1'b0);
    exp_q.delete();
    pulse_cyc.delete();
    push_init();
    tick();
    sys_reset = 1'b0;
    for (int i = 0; i < 200 && !o_init_done; i++) tick();
    chk("reinit_done", o_init_done, 1'b1);
    chk("reinit_count", pulse_cyc.size(), 7);
    repeat (40) tick();
    chk("aborted_not_sent", n_done, done_before);
    chk("reinit_drained", exp_q.size(), 0);
    chk("idle_ready", o_tx_ready, 1'b1);

    chk("total_tx_done", n_done, 3);
    chk("total_err", n_err, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
